// File: rtl/rle_pkg.sv
// Shared definitions for the RLE capture controller: sizes, state encoding and small helpers.
package rle_pkg;

    localparam int DATA_W       = 16;
    localparam int DEPTH_W      = 25;
    localparam int FIFO_AW      = 3;
    localparam int FLUSH_TMO    = 4;
    localparam int RLE_FLAG_BIT = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == S_ARMED) || (s == S_RUN) || (s == S_FLUSH) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/rle_capture_ctrl_if.sv
// Valid/ready link from the capture FIFO head to the sample-memory writer.
interface rle_capture_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;
    logic              mem_ready;

    modport master (output mem_data, output mem_valid, input mem_ready);
    modport slave  (input mem_data, input mem_valid, output mem_ready);
endinterface

// File: rtl/rle_fifo.sv
// First-word-fall-through FIFO with synchronous clear; caller only pushes when space is
// available (or a pop frees a slot in the same cycle) and only pops when non-empty.
module rle_fifo #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);

    localparam int ENTRIES = 1 << AW;

    logic [DATA_W-1:0] mem [ENTRIES];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [AW:0]       cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (push && !pop) begin
            cnt_d = cnt + (AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt   <= cnt_d;
            empty <= (cnt_d == '0);
            full  <= (cnt_d == (AW+1)'(ENTRIES));
        end
    end

    // On a full FIFO a simultaneous push overwrites the head slot that is being popped.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/rle_capture_ctrl.sv
// Sequences one acquisition through the run-length encoder and buffers stored words
// toward the sample-memory writer.
//
//   state  | meaning
//   IDLE   | waiting for cfg_start
//   ARMED  | waiting for trig_hit
//   RUN    | storing raw samples or encoder words
//   FLUSH  | enc_flush issued, waiting up to FLUSH_TMO cycles for the closing word
//   DRAIN  | encoder stopped, emptying the FIFO
//   DONE   | capture complete, done held high
module rle_capture_ctrl #(
    parameter int DEPTH_W   = rle_pkg::DEPTH_W,
    parameter int DATA_W    = rle_pkg::DATA_W,
    parameter int FIFO_AW   = rle_pkg::FIFO_AW,
    parameter int FLUSH_TMO = rle_pkg::FLUSH_TMO
) (
    input  logic                core_clk,
    input  logic                core_rst_n,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                cfg_rle_mode,
    input  logic [DEPTH_W-1:0]  cfg_depth,
    input  logic                trig_hit,
    input  logic [DATA_W-1:0]   capture_data,
    input  logic                enc_valid,
    input  logic [DATA_W-1:0]   enc_data,
    output logic                enc_run,
    output logic                enc_flush,
    rle_capture_ctrl_if.master  mem,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [DEPTH_W-1:0]  word_cnt,
    output logic [2:0]          state
);
    import rle_pkg::*;

    localparam int               TMO_W    = $clog2(FLUSH_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(FLUSH_TMO - 1);

    state_t              state_q;
    state_t              state_d;
    logic [DEPTH_W-1:0]  push_cnt_q;
    logic [DEPTH_W-1:0]  push_cnt_d;
    logic [DEPTH_W-1:0]  push_next;
    logic [DEPTH_W-1:0]  depth_eff;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_d;
    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic                fifo_clr;
    logic                clr_stats;
    logic                fifo_empty;
    logic                fifo_full;
    logic [DATA_W-1:0]   push_data;
    logic [DATA_W-1:0]   fifo_rdata;

    // push_cnt counts push attempts (including dropped words) so depth ends the capture
    // even when the memory writer stalls.
    assign depth_eff = (cfg_depth == '0) ? DEPTH_W'(1) : cfg_depth;
    assign push_next = push_cnt_q + DEPTH_W'(1);
    assign pop       = mem.mem_valid & mem.mem_ready;
    assign push_ok   = push_req & (~fifo_full | pop);

    always_comb begin
        state_d    = state_q;
        push_cnt_d = push_cnt_q;
        tmo_d      = tmo_q;
        push_req   = 1'b0;
        push_data  = capture_data;
        fifo_clr   = 1'b0;
        clr_stats  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start) begin
                    state_d    = S_ARMED;
                    push_cnt_d = '0;
                    fifo_clr   = 1'b1;
                    clr_stats  = 1'b1;
                end
            end
            S_ARMED: begin
                if (trig_hit) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!cfg_rle_mode) begin
                    push_req   = 1'b1;
                    push_cnt_d = push_next;
                    if (push_next == depth_eff) begin
                        state_d = S_DRAIN;
                    end
                end else if (depth_eff == DEPTH_W'(1)) begin
                    state_d = S_FLUSH;
                    tmo_d   = TMO_LOAD;
                end else if (enc_valid) begin
                    push_req   = 1'b1;
                    push_data  = enc_data;
                    push_cnt_d = push_next;
                    if (push_next == depth_eff - DEPTH_W'(1)) begin
                        state_d = S_FLUSH;
                        tmo_d   = TMO_LOAD;
                    end
                end
            end
            S_FLUSH: begin
                if (enc_valid) begin
                    push_req  = 1'b1;
                    push_data = enc_data;
                    state_d   = S_DRAIN;
                end else if (tmo_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            S_DRAIN: begin
                if (!mem.mem_valid) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (cfg_abort) begin
            state_d  = S_IDLE;
            push_req = 1'b0;
            fifo_clr = 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q    <= S_IDLE;
            push_cnt_q <= '0;
            tmo_q      <= '0;
            enc_run    <= 1'b0;
            enc_flush  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            push_cnt_q <= push_cnt_d;
            tmo_q      <= tmo_d;
            enc_run    <= (state_d == S_RUN) || (state_d == S_FLUSH);
            enc_flush  <= (state_d == S_FLUSH) && (state_q != S_FLUSH);
            busy       <= is_busy(state_d);
            done       <= (state_d == S_DONE);
            if (clr_stats) begin
                word_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) begin
                    word_cnt <= word_cnt + DEPTH_W'(1);
                end
                if (push_req && !push_ok) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    rle_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk   (core_clk),
        .rst_n (core_rst_n),
        .clr   (fifo_clr),
        .push  (push_ok),
        .pop   (pop),
        .wdata (push_data),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign mem.mem_data  = fifo_rdata;
    assign mem.mem_valid = ~fifo_empty;
    assign state         = state_q;

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// Self-checking bench for rle_capture_ctrl: scenario tasks against a word-list reference model.
module tb_rle_capture_ctrl;
    import rle_pkg::*;

    logic        core_clk     = 1'b0;
    logic        core_rst_n   = 1'b0;
    logic        cfg_start    = 1'b0;
    logic        cfg_abort    = 1'b0;
    logic        cfg_rle_mode = 1'b0;
    logic [24:0] cfg_depth    = '0;
    logic        trig_hit     = 1'b0;
    logic [15:0] capture_data = '0;
    logic        enc_valid    = 1'b0;
    logic [15:0] enc_data     = '0;
    logic        enc_run;
    logic        enc_flush;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [24:0] word_cnt;
    logic [2:0]  state;

    rle_capture_ctrl_if #(.DATA_W(16)) mem ();

    rle_capture_ctrl dut (
        .core_clk     (core_clk),
        .core_rst_n   (core_rst_n),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_rle_mode (cfg_rle_mode),
        .cfg_depth    (cfg_depth),
        .trig_hit     (trig_hit),
        .capture_data (capture_data),
        .enc_valid    (enc_valid),
        .enc_data     (enc_data),
        .enc_run      (enc_run),
        .enc_flush    (enc_flush),
        .mem          (mem),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .word_cnt     (word_cnt),
        .state        (state)
    );

    always #5 core_clk = ~core_clk;

    logic [15:0] got [$];
    logic [15:0] exp_q [$];
    int          run_cycles   = 0;
    int          flush_pulses = 0;
    int          n_checks     = 0;
    int          n_pass       = 0;
    bit          rand_ready   = 1'b0;

    // Words leaving the FIFO are those seen valid & ready half a cycle before the pop edge.
    always @(negedge core_clk) begin
        if (mem.mem_valid && mem.mem_ready) got.push_back(mem.mem_data);
        if (enc_run) run_cycles++;
        if (enc_flush) flush_pulses++;
    end

    task automatic step();
        @(posedge core_clk);
        #1;
        capture_data = capture_data + 16'd1;
        if (rand_ready) mem.mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_capture(input bit rle, input int depth, input bit ready);
        cfg_rle_mode  = rle;
        cfg_depth     = 25'(depth);
        mem.mem_ready = ready;
        cfg_start     = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic fire_trigger(output logic [15:0] tv);
        tv       = capture_data;
        trig_hit = 1'b1;
        step();
        trig_hit = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (state == s) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Streams n encoder words, then sends a flagged closing word `delay` cycles after
    // enc_flush (none if delay < 0). Only a closing word inside the timeout window is expected.
    task automatic rle_stream(input int n, input int delay, input logic [15:0] fw, output bit seen);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            w = 16'($urandom);
            w[RLE_FLAG_BIT] = 1'b0;
            enc_valid = 1'b1;
            enc_data  = w;
            exp_q.push_back(w);
            step();
            enc_valid = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (enc_flush) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (delay >= 0) begin
            repeat (delay) step();
            enc_valid = 1'b1;
            enc_data  = fw;
            step();
            enc_valid = 1'b0;
            if (delay < FLUSH_TMO) exp_q.push_back(fw);
        end
    endtask

    function automatic int word_errors(input int base);
        int n = 0;
        if (got.size() - base != exp_q.size()) n++;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= got.size() || got[base + i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        core_rst_n    = 1'b0;
        mem.mem_ready = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        n_checks++;
        if ({state, enc_run, enc_flush, mem.mem_valid, busy, done, overflow} !== 9'b0)
            $display("FAIL reset_outputs: got %b required 0", {state, enc_run, enc_flush, mem.mem_valid, busy, done, overflow});
        else n_pass++;
        n_checks++;
        if (word_cnt !== 25'd0) $display("FAIL reset_word_cnt: got %0d required 0", word_cnt);
        else n_pass++;
        core_rst_n = 1'b1;
        step();
        n_checks++;
        if (state !== 3'd0) $display("FAIL reset_idle: got %0d required 0", state);
        else n_pass++;
    endtask

    task automatic test_rle_basic();
        bit ok;
        logic [15:0] tv;
        int base = got.size();
        int fp0  = flush_pulses;
        exp_q.delete();
        start_capture(1'b1, 4, 1'b1);
        n_checks++;
        if (state !== 3'd1 || busy !== 1'b1) $display("FAIL rle_armed: got state %0d busy %b required 1/1", state, busy);
        else n_pass++;
        fire_trigger(tv);
        rle_stream(3, 2, 16'h8005, ok);
        n_checks++;
        if (!ok) $display("FAIL rle_flush_seen: got 0 required 1");
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL rle_done: got 0 required 1");
        else n_pass++;
        n_checks++;
        if (word_errors(base) != 0) $display("FAIL rle_words: got %0d words required %0d", got.size() - base, exp_q.size());
        else n_pass++;
        n_checks++;
        if ((got.size() > 0 ? got[got.size() - 1] : 16'hxxxx) !== 16'h8005)
            $display("FAIL rle_last_word: got %h required 8005", got.size() > 0 ? got[got.size() - 1] : 16'hxxxx);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 25'd4) $display("FAIL rle_word_cnt: got %0d required 4", word_cnt);
        else n_pass++;
        n_checks++;
        if (flush_pulses - fp0 != 1) $display("FAIL rle_flush_pulse: got %0d required 1", flush_pulses - fp0);
        else n_pass++;
        n_checks++;
        if (state !== 3'd5 || busy !== 1'b0) $display("FAIL rle_final_state: got state %0d busy %b required 5/0", state, busy);
        else n_pass++;
    endtask

    task automatic test_rle_timeout();
        bit ok;
        logic [15:0] tv;
        int fl   = 0;
        int base = got.size();
        exp_q.delete();
        start_capture(1'b1, 3, 1'b1);
        fire_trigger(tv);
        rle_stream(2, -1, 16'h0, ok);
        while (state == 3'd3 && fl < 20) begin
            fl++;
            step();
        end
        n_checks++;
        if (fl != FLUSH_TMO) $display("FAIL tmo_flush_cycles: got %0d required %0d", fl, FLUSH_TMO);
        else n_pass++;
        n_checks++;
        if (state !== 3'd4) $display("FAIL tmo_drain: got %0d required 4", state);
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok || word_cnt !== 25'd2 || overflow !== 1'b0)
            $display("FAIL tmo_result: got done %b cnt %0d ovf %b required 1/2/0", ok, word_cnt, overflow);
        else n_pass++;
        n_checks++;
        if (word_errors(base) != 0) $display("FAIL tmo_words: got %0d words required %0d", got.size() - base, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_raw();
        bit ok;
        logic [15:0] tv;
        int r0;
        int base = got.size();
        exp_q.delete();
        start_capture(1'b0, 10, 1'b1);
        repeat (18) step();
        r0 = run_cycles;
        fire_trigger(tv);
        for (int i = 1; i <= 10; i++) exp_q.push_back(16'(tv + 16'(i)));
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL raw_done: got 0 required 1");
        else n_pass++;
        n_checks++;
        if (word_errors(base) != 0) $display("FAIL raw_words: got %0d words required %0d", got.size() - base, exp_q.size());
        else n_pass++;
        n_checks++;
        if (run_cycles - r0 != 10) $display("FAIL raw_enc_run: got %0d cycles required 10", run_cycles - r0);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 25'd10 || overflow !== 1'b0) $display("FAIL raw_cnt: got %0d ovf %b required 10/0", word_cnt, overflow);
        else n_pass++;
    endtask

    task automatic test_raw_overflow();
        bit ok;
        logic [15:0] tv;
        int base = got.size();
        exp_q.delete();
        start_capture(1'b0, 20, 1'b0);
        fire_trigger(tv);
        wait_state(3'd4, ok);
        n_checks++;
        if (!ok) $display("FAIL ovf_reach_drain: got state %0d required 4", state);
        else n_pass++;
        n_checks++;
        if (word_cnt !== 25'd8 || overflow !== 1'b1 || mem.mem_valid !== 1'b1 || done !== 1'b0)
            $display("FAIL ovf_status: got cnt %0d ovf %b valid %b done %b required 8/1/1/0", word_cnt, overflow, mem.mem_valid, done);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (mem.mem_data !== 16'(tv + 16'd1) || state !== 3'd4)
            $display("FAIL ovf_hold: got %h state %0d required %h state 4", mem.mem_data, state, 16'(tv + 16'd1));
        else n_pass++;
        for (int i = 1; i <= 8; i++) exp_q.push_back(16'(tv + 16'(i)));
        mem.mem_ready = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok || word_errors(base) != 0)
            $display("FAIL ovf_drain: got done %b words %0d required 1/%0d", ok, got.size() - base, exp_q.size());
        else n_pass++;
        n_checks++;
        if (word_cnt !== 25'd8) $display("FAIL ovf_final_cnt: got %0d required 8", word_cnt);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        logic [15:0] tv;
        int base;
        start_capture(1'b0, 20, 1'b0);
        n_checks++;
        if (overflow !== 1'b0 || word_cnt !== 25'd0 || done !== 1'b0)
            $display("FAIL start_clears: got ovf %b cnt %0d done %b required 0/0/0", overflow, word_cnt, done);
        else n_pass++;
        fire_trigger(tv);
        repeat (5) step();
        n_checks++;
        if (word_cnt !== 25'd5 || mem.mem_valid !== 1'b1) $display("FAIL abort_pre: got cnt %0d valid %b required 5/1", word_cnt, mem.mem_valid);
        else n_pass++;
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        n_checks++;
        if (state !== 3'd0 || mem.mem_valid !== 1'b0 || enc_run !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_idle: got state %0d valid %b run %b busy %b required 0/0/0/0", state, mem.mem_valid, enc_run, busy);
        else n_pass++;
        exp_q.delete();
        start_capture(1'b0, 3, 1'b1);
        n_checks++;
        if (word_cnt !== 25'd0 || state !== 3'd1) $display("FAIL rearm: got cnt %0d state %0d required 0/1", word_cnt, state);
        else n_pass++;
        base = got.size();
        fire_trigger(tv);
        for (int i = 1; i <= 3; i++) exp_q.push_back(16'(tv + 16'(i)));
        wait_done(ok);
        n_checks++;
        if (!ok || word_errors(base) != 0)
            $display("FAIL rearm_words: got done %b words %0d required 1/%0d", ok, got.size() - base, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [15:0] tv;
        int base = got.size();
        exp_q.delete();
        start_capture(1'b0, 6, 1'b1);
        fire_trigger(tv);
        for (int i = 1; i <= 6; i++) exp_q.push_back(16'(tv + 16'(i)));
        repeat (2) step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        n_checks++;
        if (state !== 3'd2) $display("FAIL start_in_run: got state %0d required 2", state);
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok || word_errors(base) != 0 || word_cnt !== 25'd6)
            $display("FAIL start_in_run_words: got done %b words %0d cnt %0d required 1/6/6", ok, got.size() - base, word_cnt);
        else n_pass++;
    endtask

    task automatic test_trig_abort();
        int r0;
        start_capture(1'b1, 5, 1'b1);
        r0        = run_cycles;
        trig_hit  = 1'b1;
        cfg_abort = 1'b1;
        step();
        trig_hit  = 1'b0;
        cfg_abort = 1'b0;
        n_checks++;
        if (state !== 3'd0) $display("FAIL trig_abort_state: got %0d required 0", state);
        else n_pass++;
        repeat (5) step();
        n_checks++;
        if (run_cycles - r0 != 0 || busy !== 1'b0)
            $display("FAIL trig_abort_run: got %0d run cycles busy %b required 0/0", run_cycles - r0, busy);
        else n_pass++;
    endtask

    task automatic test_reset_drain();
        bit ok;
        logic [15:0] tv;
        start_capture(1'b0, 20, 1'b0);
        fire_trigger(tv);
        wait_state(3'd4, ok);
        #2;
        core_rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || {state, enc_run, enc_flush, mem.mem_valid, busy, done, overflow} !== 9'b0 || word_cnt !== 25'd0)
            $display("FAIL reset_in_drain: got %b cnt %0d required 0/0", {state, enc_run, enc_flush, mem.mem_valid, busy, done, overflow}, word_cnt);
        else n_pass++;
        @(negedge core_clk);
        core_rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        bit ok;
        bit rle;
        int depth;
        int eff;
        int dly;
        int base;
        logic [15:0] tv;
        logic [15:0] fw;
        for (int it = 0; it < 10; it++) begin
            rle   = 1'($urandom_range(0, 1));
            depth = $urandom_range(0, 8);
            if (it == 0) begin
                rle   = 1'b0;
                depth = 0;
            end
            if (it == 1) begin
                rle   = 1'b1;
                depth = 1;
            end
            eff  = (depth == 0) ? 1 : depth;
            dly  = $urandom_range(0, 5);
            fw   = 16'($urandom);
            fw[RLE_FLAG_BIT] = 1'b1;
            exp_q.delete();
            base = got.size();
            start_capture(rle, depth, 1'b1);
            rand_ready = 1'b1;
            fire_trigger(tv);
            if (rle) begin
                rle_stream(eff - 1, dly, fw, ok);
            end else begin
                for (int i = 1; i <= eff; i++) exp_q.push_back(16'(tv + 16'(i)));
            end
            wait_done(ok);
            rand_ready    = 1'b0;
            mem.mem_ready = 1'b1;
            n_checks++;
            if (!ok || word_errors(base) != 0)
                $display("FAIL rand_words it%0d: got done %b words %0d required 1/%0d", it, ok, got.size() - base, exp_q.size());
            else n_pass++;
            n_checks++;
            if (word_cnt !== 25'(exp_q.size()) || overflow !== 1'b0)
                $display("FAIL rand_cnt it%0d: got %0d ovf %b required %0d/0", it, word_cnt, overflow, exp_q.size());
            else n_pass++;
        end
    endtask

    initial begin
        mem.mem_ready = 1'b0;
        test_reset();
        test_rle_basic();
        test_rle_timeout();
        test_raw();
        test_raw_overflow();
        test_abort();
        test_start_ignored();
        test_trig_abort();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
